// File: rtl/i_delay_eye_cal_pkg.sv
// Shared types and constants for the I_DELAY eye calibration block.
package i_delay_eye_cal_pkg;

  localparam int unsigned TAP_W   = 6;
  localparam int unsigned TAP_MAX = 63;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SET_W   = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    STEP   = 3'd4,
    CENTER = 3'd5,
    DONE   = 3'd6,
    FAIL   = 3'd7
  } state_e;

endpackage

// File: rtl/i_delay_eye_cal_alt_pattern_chk.sv
// Alternating-pattern checker: takes WIN_LEN+1 samples after start and passes
// only if no sample equals its predecessor.
module alt_pattern_chk
  import i_delay_eye_cal_pkg::*;
#(
  parameter int unsigned WIN_LEN = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic sample,
  output logic done,
  output logic pass
);

  logic             active_q;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] mism_q;
  logic             dup_c;

  // The first sample has no predecessor, so it can never be a mismatch.
  assign dup_c = (cnt_q != '0) && (sample == prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      mism_q   <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        active_q <= 1'b1;
        cnt_q    <= '0;
        mism_q   <= '0;
      end else if (active_q) begin
        prev_q <= sample;
        cnt_q  <= cnt_q + 1'b1;
        if (dup_c && (mism_q != '1)) begin
          mism_q <= mism_q + 1'b1;
        end
        if (cnt_q == CNT_W'(WIN_LEN)) begin
          active_q <= 1'b0;
          done     <= 1'b1;
          pass     <= (mism_q == '0) && !dup_c;
        end
      end
    end
  end

endmodule

// File: rtl/i_delay_eye_cal.sv
// Sweeps the I_DELAY tap from 0 upward, finds the passing eye on a 1010
// training pattern, then steps back to the eye center and verifies readback.
module i_delay_eye_cal
  import i_delay_eye_cal_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned WIN_LEN    = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             data_dly_i,
  input  logic [TAP_W-1:0] dly_tap_val_i,
  output logic             dly_ld_o,
  output logic             dly_adj_o,
  output logic             dly_incdec_o,
  output logic             busy_o,
  output logic             cal_done_o,
  output logic             cal_fail_o,
  output logic [TAP_W-1:0] eye_start_o,
  output logic [TAP_W-1:0] eye_end_o,
  output logic [TAP_W-1:0] tap_center_o
);

  localparam int unsigned SETTLE_LAST = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
  localparam int unsigned SUM_W       = TAP_W + 1;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic               seen_q, seen_d;
  logic               centering_q, centering_d;
  logic               gap_q, gap_d;
  logic               data_q;
  logic [TAP_W-1:0]   eye_start_d, eye_end_d, center_d;
  logic [SUM_W-1:0]   sum_c;
  logic               ld_d, adj_d, incdec_d, busy_d, done_d, fail_d;
  logic               chk_start_c;
  logic               chk_done, chk_pass;

  alt_pattern_chk #(.WIN_LEN(WIN_LEN)) u_chk (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .start  (chk_start_c),
    .sample (data_q),
    .done   (chk_done),
    .pass   (chk_pass)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state: sweep ends on tap 63, on the first fail after a pass, or in FAIL with no eye.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, FAIL: if (start_i) state_d = LOAD;
      LOAD:             state_d = SETTLE;
      SETTLE: begin
        if (settle_q == SET_W'(SETTLE_LAST)) begin
          if (!centering_q)                      state_d = CHECK;
          else if (dly_tap_val_i == tap_center_o) state_d = DONE;
          else                                    state_d = FAIL;
        end
      end
      CHECK: begin
        if (chk_done) begin
          if (chk_pass)                         state_d = (tap_q == TAP_W'(TAP_MAX)) ? CENTER : STEP;
          else if (seen_q)                      state_d = CENTER;
          else if (tap_q == TAP_W'(TAP_MAX))    state_d = FAIL;
          else                                  state_d = STEP;
        end
      end
      STEP:   state_d = SETTLE;
      CENTER: if (tap_q == tap_center_o) state_d = SETTLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath next values; every output is registered from these.
  always_comb begin
    settle_d    = '0;
    tap_d       = tap_q;
    seen_d      = seen_q;
    centering_d = centering_q;
    gap_d       = 1'b0;
    eye_start_d = eye_start_o;
    eye_end_d   = eye_end_o;
    center_d    = tap_center_o;
    adj_d       = 1'b0;
    chk_start_c = 1'b0;
    case (state_q)
      IDLE, DONE, FAIL: begin
        if (start_i) begin
          eye_start_d = '0;
          eye_end_d   = '0;
          center_d    = '0;
          seen_d      = 1'b0;
          centering_d = 1'b0;
        end
      end
      LOAD: tap_d = '0;
      SETTLE: begin
        settle_d = settle_q + 1'b1;
        if (state_d == CHECK) chk_start_c = 1'b1;
      end
      CHECK: begin
        if (chk_done && chk_pass) begin
          if (!seen_q) eye_start_d = tap_q;
          eye_end_d = tap_q;
          seen_d    = 1'b1;
        end
        if (state_d == CENTER) centering_d = 1'b1;
      end
      STEP: tap_d = tap_q + 1'b1;
      CENTER: begin
        // Decrement pulses alternate with an idle gap cycle.
        if (state_d == CENTER) begin
          gap_d = !gap_q;
          if (!gap_q) begin
            adj_d = 1'b1;
            tap_d = tap_q - 1'b1;
          end
        end
      end
      default: ;
    endcase
    sum_c = SUM_W'(eye_start_d) + SUM_W'(eye_end_d);
    if ((state_q == CHECK) && (state_d == CENTER)) center_d = sum_c[SUM_W-1:1];
    ld_d     = (state_d == LOAD);
    adj_d    = adj_d | (state_d == STEP);
    incdec_d = (state_d == STEP);
    busy_d   = !(state_d inside {IDLE, DONE, FAIL});
    done_d   = (state_d == DONE);
    fail_d   = (state_d == FAIL);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      settle_q     <= '0;
      tap_q        <= '0;
      seen_q       <= 1'b0;
      centering_q  <= 1'b0;
      gap_q        <= 1'b0;
      data_q       <= 1'b0;
      dly_ld_o     <= 1'b0;
      dly_adj_o    <= 1'b0;
      dly_incdec_o <= 1'b0;
      busy_o       <= 1'b0;
      cal_done_o   <= 1'b0;
      cal_fail_o   <= 1'b0;
      eye_start_o  <= '0;
      eye_end_o    <= '0;
      tap_center_o <= '0;
    end else begin
      settle_q     <= settle_d;
      tap_q        <= tap_d;
      seen_q       <= seen_d;
      centering_q  <= centering_d;
      gap_q        <= gap_d;
      data_q       <= data_dly_i;
      dly_ld_o     <= ld_d;
      dly_adj_o    <= adj_d;
      dly_incdec_o <= incdec_d;
      busy_o       <= busy_d;
      cal_done_o   <= done_d;
      cal_fail_o   <= fail_d;
      eye_start_o  <= eye_start_d;
      eye_end_o    <= eye_end_d;
      tap_center_o <= center_d;
    end
  end

endmodule

// File: tb/tb_i_delay_eye_cal.sv
// Bench for i_delay_eye_cal: behavioural I_DELAY model, directed eye scenarios,
// and a result scoreboard checked by an independent monitor.
module tb_i_delay_eye_cal;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       data_dly;
  logic [5:0] tap_val;
  logic       dly_ld, dly_adj, dly_incdec, busy, cal_done, cal_fail;
  logic [5:0] eye_start, eye_end, tap_center;

  always #5 clk = ~clk;

  i_delay_eye_cal #(.SETTLE_CYC(8), .WIN_LEN(32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .data_dly_i    (data_dly),
    .dly_tap_val_i (tap_val),
    .dly_ld_o      (dly_ld),
    .dly_adj_o     (dly_adj),
    .dly_incdec_o  (dly_incdec),
    .busy_o        (busy),
    .cal_done_o    (cal_done),
    .cal_fail_o    (cal_fail),
    .eye_start_o   (eye_start),
    .eye_end_o     (eye_end),
    .tap_center_o  (tap_center)
  );

  // I_DELAY model: clean toggle inside the eye, every sample doubled outside it.
  int         eye_lo = 99;
  int         eye_hi = -1;
  bit         stuck = 1'b0;
  logic [5:0] model_tap = 6'd37;
  logic [1:0] ph = 2'd0;

  always @(posedge clk) begin
    ph <= ph + 2'd1;
    if (dly_ld)       model_tap <= 6'd0;
    else if (dly_adj) model_tap <= dly_incdec ? model_tap + 6'd1 : model_tap - 6'd1;
  end

  assign data_dly = (int'(model_tap) >= eye_lo && int'(model_tap) <= eye_hi) ? ph[0] : ph[1];
  assign tap_val  = stuck ? 6'd12 : model_tap;

  int   n_ld = 0, n_inc = 0, n_dec = 0, n_overlap = 0;
  logic cnt_clr = 1'b0;

  always @(posedge clk) begin
    if (dly_ld && dly_adj) n_overlap <= n_overlap + 1;
    if (cnt_clr) begin
      n_ld <= 0; n_inc <= 0; n_dec <= 0;
    end else begin
      if (dly_ld)                n_ld  <= n_ld + 1;
      if (dly_adj && dly_incdec)  n_inc <= n_inc + 1;
      if (dly_adj && !dly_incdec) n_dec <= n_dec + 1;
    end
  end

  typedef struct {
    int run;
    bit done;
    int es, ee, ctr;
    int inc, dec;
    bit chk_tap;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0, n_res = 0;

  task automatic check(string nm, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  function automatic exp_t mk(int run, bit done, int es, int ee, int ctr,
                              int inc, int dec, bit chk_tap);
    exp_t e;
    e.run = run; e.done = done; e.es = es; e.ee = ee; e.ctr = ctr;
    e.inc = inc; e.dec = dec; e.chk_tap = chk_tap;
    return e;
  endfunction

  // Monitor: pops one expectation per rising cal_done/cal_fail.
  task automatic monitor();
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if ((cal_done || cal_fail) && !prev) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_result: got done=%0d fail=%0d, want no result", cal_done, cal_fail);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("run%0d_done", e.run), int'(cal_done), int'(e.done));
          check($sformatf("run%0d_fail", e.run), int'(cal_fail), int'(!e.done));
          check($sformatf("run%0d_eye_start", e.run), int'(eye_start), e.es);
          check($sformatf("run%0d_eye_end", e.run), int'(eye_end), e.ee);
          check($sformatf("run%0d_center", e.run), int'(tap_center), e.ctr);
          check($sformatf("run%0d_inc_pulses", e.run), n_inc, e.inc);
          check($sformatf("run%0d_dec_pulses", e.run), n_dec, e.dec);
          check($sformatf("run%0d_ld_pulses", e.run), n_ld, 1);
          check($sformatf("run%0d_busy", e.run), int'(busy), 0);
          if (e.chk_tap) check($sformatf("run%0d_tap_readback", e.run), int'(tap_val), e.ctr);
        end
        n_res++;
      end
      prev = cal_done || cal_fail;
    end
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_ld"}, int'(dly_ld), 0);
    check({tag, "_adj"}, int'(dly_adj), 0);
    check({tag, "_incdec"}, int'(dly_incdec), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(cal_done), 0);
    check({tag, "_fail"}, int'(cal_fail), 0);
    check({tag, "_eye_start"}, int'(eye_start), 0);
    check({tag, "_eye_end"}, int'(eye_end), 0);
    check({tag, "_center"}, int'(tap_center), 0);
  endtask

  task automatic run_cal(int lo, int hi, bit stk, exp_t e, int mid_tap);
    int target;
    bit kicked;
    target = n_res + 1;
    kicked = 1'b0;
    eye_lo = lo; eye_hi = hi; stuck = stk;
    exp_q.push_back(e);
    @(negedge clk); cnt_clr = 1'b1; start = 1'b1;
    @(negedge clk); cnt_clr = 1'b0; start = 1'b0;
    for (int i = 0; i < 20000 && n_res < target; i++) begin
      @(negedge clk);
      if (!kicked && mid_tap >= 0 && int'(model_tap) == mid_tap && busy) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        kicked = 1'b1;
      end
    end
    if (n_res < target) begin
      n_chk++; n_fail++;
      $display("FAIL run%0d_timeout: got no result, want result within 20000 cycles", e.run);
      exp_q.delete();
    end
  endtask

  initial begin
    int waited;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_self_start_busy", int'(busy), 0);
    check("no_self_start_ld", n_ld, 0);

    // Eye 20..40: sweep stops on failing tap 41, steps back 11 to center 30.
    run_cal(20, 40, 1'b0, mk(1, 1'b1, 20, 40, 30, 41, 11, 1'b1), -1);
    // Eye reaching tap 63: center (50+63)>>1 = 56, seven steps back.
    run_cal(50, 63, 1'b0, mk(2, 1'b1, 50, 63, 56, 63, 7, 1'b1), -1);
    // No eye at all.
    run_cal(99, -1, 1'b0, mk(3, 1'b0, 0, 0, 0, 63, 0, 1'b0), -1);
    // Single passing tap 10, with a stray start at tap 5; sweep ends at tap 11, one step back.
    run_cal(10, 10, 1'b0, mk(4, 1'b1, 10, 10, 10, 11, 1, 1'b1), 5);

    // Reset in the middle of a sweep.
    eye_lo = 20; eye_hi = 40; stuck = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    waited = 0;
    while (int'(model_tap) != 25 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    check("reach_tap25_in_time", int'(waited < 5000), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midsweep_reset");
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("after_reset_ld", n_ld, 0);
    check("after_reset_adj", n_inc + n_dec, 0);
    check("after_reset_busy", int'(busy), 0);
    run_cal(20, 40, 1'b0, mk(5, 1'b1, 20, 40, 30, 41, 11, 1'b1), -1);

    // Readback stuck at 12 while the eye is 20..40.
    run_cal(20, 40, 1'b1, mk(6, 1'b0, 20, 40, 30, 41, 11, 1'b0), -1);

    check("ld_adj_overlap_cycles", n_overlap, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
